i2c_txn_arbiter: RTL

- Shares one byte-level I2C master command port among NUM_REQ requesters.
- Arbitration is round-robin at transaction granularity. Once a requester's START completes, it holds the bus until its STOP completes, or until an error or arbitration loss.
- Responses from the master are routed back to the owning requester only.
- Sits between on-chip command sources and the I2C master core that drives scl/sda.

---
 rtl/i2c_arb_pkg.sv | 39 +++
 rtl/i2c_txn_arbiter_rr_pick.sv | 30 +++
 rtl/i2c_txn_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C transaction arbiter: command/status encodings,
// field widths and the arbiter FSM state type.
package i2c_arb_pkg;

  localparam int CMD_WIDTH = 3;
  localparam int RSP_WIDTH = 2;

  // Code 7 is reserved; it is carried as a raw 3-bit value, not an enum member.
  typedef enum logic [CMD_WIDTH-1:0] {
    CMD_WAIT     = 3'd0,
    CMD_WRITE    = 3'd1,
    CMD_READ_ACK = 3'd2,
    CMD_READ_NAK = 3'd3,
    CMD_START    = 3'd4,
    CMD_STOP     = 3'd5,
    CMD_SET_BUS  = 3'd6
  } i2c_cmd_t;

  typedef enum logic [RSP_WIDTH-1:0] {
    RSP_DONE     = 2'd0,
    RSP_NAK      = 2'd1,
    RSP_ARB_LOST = 2'd2,
    RSP_ERR      = 2'd3
  } i2c_rsp_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    OWNED      = 3'd1,
    BUSY       = 3'd2,
    FORCE_STOP = 3'd3,
    FORCE_WAIT = 3'd4
  } arb_state_t;

  // Statuses that end a transaction regardless of the lock.
  function automatic logic rsp_is_fatal(input logic [RSP_WIDTH-1:0] st);
    return (st == RSP_ARB_LOST) || (st == RSP_ERR);
  endfunction

endpackage

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Picks the first set request
// at or after ptr, wrapping, and returns it one-hot and as an index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int j;

  // Scan from farthest to nearest so the nearest set bit wins without a break.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: shares one byte-level I2C master command port among
// NUM_REQ requesters with round-robin arbitration at transaction granularity.
// A START answered DONE locks the bus to its owner until STOP, ARB_LOST/ERR.
// Optional build macro I2C_ARB_TIMEOUT_EN: a locked owner that stays silent
// for TIMEOUT_CYC cycles gets a forced STOP and an ERR response.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_cmd_valid,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]    req_cmd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_cmd_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [RSP_WIDTH-1:0]            rsp_status,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            m_cmd_valid,
  output logic [CMD_WIDTH-1:0]            m_cmd,
  output logic [DATA_WIDTH-1:0]           m_data,
  input  logic                            m_cmd_ready,
  input  logic                            m_rsp_valid,
  input  logic [RSP_WIDTH-1:0]            m_rsp_status,
  input  logic [DATA_WIDTH-1:0]           m_rsp_data
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Per-requester views of the flat command/data buses.
  logic [CMD_WIDTH-1:0]  cmd_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign cmd_arr[g]  = req_cmd[g*CMD_WIDTH +: CMD_WIDTH];
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  arb_state_t             state_q, state_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic                   lock_q, lock_d;
  logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
  logic [NUM_REQ-1:0]     rspv_q, rspv_d;
  logic [RSP_WIDTH-1:0]   rsps_q, rsps_d;
  logic [DATA_WIDTH-1:0]  rspd_q, rspd_d;

  logic [NUM_REQ-1:0]     pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic [IW-1:0]          ptr_nxt;
  logic                   owner_vld;
  logic                   release_now;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]          cnt_q, cnt_d;
`endif

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
    .req (req_cmd_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign owner_vld = req_cmd_valid[owner_q];
  assign ptr_nxt   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  assign grant      = grant_q;
  assign rsp_valid  = rspv_q;
  assign rsp_status = rsps_q;
  assign rsp_data   = rspd_q;

  // Next-state, command passthrough and response capture.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    lock_d        = lock_q;
    cmd_d         = cmd_q;
    rspv_d        = '0;
    rsps_d        = rsps_q;
    rspd_d        = rspd_q;
    m_cmd_valid   = 1'b0;
    m_cmd         = '0;
    m_data        = '0;
    req_cmd_ready = '0;
    release_now   = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d         = '0;
`endif
    case (state_q)
      IDLE: begin
        if (|req_cmd_valid) begin
          owner_d = pick_idx;
          grant_d = pick_gnt;
          state_d = OWNED;
        end
      end
      OWNED: begin
        m_cmd_valid            = owner_vld;
        m_cmd                  = cmd_arr[owner_q];
        m_data                 = data_arr[owner_q];
        req_cmd_ready[owner_q] = m_cmd_ready;
        if (owner_vld && m_cmd_ready) begin
          cmd_d   = cmd_arr[owner_q];
          state_d = BUSY;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (lock_q && !owner_vld) begin
          if (cnt_q == TW'(TIMEOUT_CYC - 1)) state_d = FORCE_STOP;
          else                               cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      BUSY: begin
        if (m_rsp_valid) begin
          rspv_d = grant_q;
          rsps_d = m_rsp_status;
          rspd_d = m_rsp_data;
          if (cmd_q == CMD_START && m_rsp_status == RSP_DONE) lock_d = 1'b1;
          release_now = (cmd_q == CMD_STOP) || rsp_is_fatal(m_rsp_status) ||
                        (!lock_q && cmd_q != CMD_START);
          state_d = OWNED;
        end
      end
`ifdef I2C_ARB_TIMEOUT_EN
      FORCE_STOP: begin
        m_cmd_valid = 1'b1;
        m_cmd       = CMD_STOP;
        if (m_cmd_ready) state_d = FORCE_WAIT;
      end
      FORCE_WAIT: begin
        if (m_rsp_valid) begin
          rspv_d      = grant_q;
          rsps_d      = RSP_ERR;
          rspd_d      = m_rsp_data;
          release_now = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Release hands the bus back and moves the pointer past the old owner.
    if (release_now) begin
      state_d = IDLE;
      grant_d = '0;
      lock_d  = 1'b0;
      ptr_d   = ptr_nxt;
    end
  end

  // State and datapath registers; reset drops any ownership silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      lock_q  <= 1'b0;
      cmd_q   <= '0;
      rspv_q  <= '0;
      rsps_q  <= '0;
      rspd_q  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      cmd_q   <= cmd_d;
      rspv_q  <= rspv_d;
      rsps_q  <= rsps_d;
      rspd_q  <= rspd_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule
